des_key_schedule: RTL and testbench

- Sequential DES key-schedule engine that produces the 16 round subkeys from a 64-bit key.
- Applies PC-1 once at start, holds the 28-bit C and D halves in registers, and rotates each half per round:
  - encrypt: rotate left (ROL1/ROL2);
  - decrypt: rotate right (ROR1/ROR2).
- Each subkey is emitted as PC-2(C,D) through a valid/ready handshake.
- Sits directly upstream of the DES round datapath, which consumes one 48-bit subkey per round.

---
 rtl/des_pkg.sv | 45 ++++
 rtl/des_key_schedule_if.sv | 24 ++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_schedule.sv | 112 +++++++++++
 tb/tb_des_key_schedule.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES key-schedule tables, constants, state type and helpers
package des_pkg;

    localparam int ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(15);

    // Bit r set means round r uses a 1-bit rotate; other rounds rotate by 2.
    localparam logic [15:0] SHIFT1_MASK = 16'b1000_0001_0000_0011;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    // Table positions are 1-based from the MSB, as in the DES standard.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1_TAB[i]];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic one);
        logic [27:0] r;
        if (left) begin
            r = one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
        end else begin
            r = one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - start/key request and subkey valid/ready bundle
import des_pkg::*;

interface des_key_schedule_if;
    logic               i_Start;
    logic [63:0]        i_Key;
    logic               i_fDecrypt;
    logic               i_Ready;
    logic               o_Valid;
    logic [47:0]        o_Subkey;
    logic [ROUND_W-1:0] o_Round;
    logic               o_Last;
    logic               o_Busy;

    modport master (
        output i_Start, i_Key, i_fDecrypt, i_Ready,
        input  o_Valid, o_Subkey, o_Round, o_Last, o_Busy
    );

    modport slave (
        input  i_Start, i_Key, i_fDecrypt, i_Ready,
        output o_Valid, o_Subkey, o_Round, o_Last, o_Busy
    );
endinterface

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 compression of {C,D} into a 48-bit subkey
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[47-i] = cd[56-PC2_TAB[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES subkey generator with valid/ready output
module des_key_schedule
    import des_pkg::*;
(
    input  logic          i_Clk,
    input  logic          i_Rst,
    des_key_schedule_if.slave bus
);

    state_t             state_q, state_d;
    logic [27:0]        c_q, d_q, c_nx, d_nx;
    logic [55:0]        pc1_val;
    logic               mode_q;
    logic [47:0]        subkey_q, pc2_out;
    logic [ROUND_W-1:0] round_q, round_nx;
    logic               valid_q, last_q, busy_q;
    logic               start_ok, accept, final_hs, step_one;
    logic               parity_unused;

    assign pc1_val  = pc1(bus.i_Key);
    // Parity bits are dropped by PC-1.
    assign parity_unused = ^{bus.i_Key[56], bus.i_Key[48], bus.i_Key[40], bus.i_Key[32],
                             bus.i_Key[24], bus.i_Key[16], bus.i_Key[8],  bus.i_Key[0]};
    assign start_ok = (state_q == IDLE) && bus.i_Start;
    assign accept   = (state_q == RUN) && valid_q && bus.i_Ready;
    assign final_hs = accept && (round_q == LAST_ROUND);
    assign round_nx = round_q + ROUND_W'(1);
    assign step_one = SHIFT1_MASK[round_nx];

    always_comb begin
        state_d = state_q;
        c_nx    = c_q;
        d_nx    = d_q;
        case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    state_d = RUN;
                    // Decrypt starts at K16, whose halves equal the PC-1 halves.
                    if (bus.i_fDecrypt) begin
                        c_nx = pc1_val[55:28];
                        d_nx = pc1_val[27:0];
                    end else begin
                        c_nx = rot28(pc1_val[55:28], 1'b1, 1'b1);
                        d_nx = rot28(pc1_val[27:0],  1'b1, 1'b1);
                    end
                end
            end
            RUN: begin
                if (accept && !final_hs) begin
                    c_nx = rot28(c_q, !mode_q, step_one);
                    d_nx = rot28(d_q, !mode_q, step_one);
                end
                if (final_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    des_pc2 u_pc2 (
        .cd     ({c_nx, d_nx}),
        .subkey (pc2_out)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            c_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            subkey_q <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            c_q <= c_nx;
            d_q <= d_nx;
            if (start_ok) begin
                mode_q   <= bus.i_fDecrypt;
                subkey_q <= pc2_out;
                round_q  <= '0;
                valid_q  <= 1'b1;
                busy_q   <= 1'b1;
                last_q   <= 1'b0;
            end else if (final_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (accept) begin
                subkey_q <= pc2_out;
                round_q  <= round_nx;
                last_q   <= (round_nx == LAST_ROUND);
            end
        end
    end

    assign bus.o_Valid  = valid_q;
    assign bus.o_Subkey = subkey_q;
    assign bus.o_Round  = round_q;
    assign bus.o_Last   = last_q;
    assign bus.o_Busy   = busy_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard bench for des_key_schedule against a table-driven DES model
module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] cap[$];
    int          hs_count = 0;
    int          checks = 0;
    int          errors = 0;
    bit          stall_en = 1'b0;

    // Subkey n (1..16): cumulative left shift of the PC-1 halves, then PC-2.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
        bit          c [28];
        bit          d [28];
        bit          cd [56];
        int          s;
        logic [47:0] k;
        s = 0;
        for (int i = 0; i < n; i++) s += SHIFTS[i];
        for (int i = 0; i < 28; i++) begin
            c[i] = key[64-PC1_T[i]];
            d[i] = key[64-PC1_T[28+i]];
        end
        for (int i = 0; i < 28; i++) begin
            cd[i]    = c[(i+s)%28];
            cd[28+i] = d[(i+s)%28];
        end
        for (int j = 0; j < 48; j++) k[47-j] = cd[PC2_T[j]-1];
        return k;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [63:0] key, input bit dec);
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.sk   = model_key(key, dec ? 16 - r : r + 1);
            e.rnd  = 4'(r);
            e.last = (r == 15);
            sb.push_back(e);
        end
    endtask

    task automatic monitor_loop();
        exp_t        e;
        bit          have_hold = 1'b0;
        logic [47:0] held_sk;
        logic [3:0]  held_rnd;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
            end else if (bus.o_Valid && bus.i_Ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {16'h0, bus.o_Subkey}, 64'h0 - 1);
                end else begin
                    e = sb.pop_front();
                    chk("subkey", {16'h0, bus.o_Subkey}, {16'h0, e.sk});
                    chk("round", {60'h0, bus.o_Round}, {60'h0, e.rnd});
                    chk("last", {63'h0, bus.o_Last}, {63'h0, e.last});
                end
                cap.push_back(bus.o_Subkey);
                hs_count++;
                have_hold = 1'b0;
            end else if (bus.o_Valid) begin
                if (have_hold) begin
                    chk("stall_hold", {12'h0, bus.o_Round, bus.o_Subkey}, {12'h0, held_rnd, held_sk});
                end
                have_hold = 1'b1;
                held_sk   = bus.o_Subkey;
                held_rnd  = bus.o_Round;
            end else begin
                have_hold = 1'b0;
            end
        end
    endtask

    task automatic ready_loop();
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && $urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 5);
                bus.i_Ready = 1'b0;
                repeat (n) @(posedge clk);
                #1;
                bus.i_Ready = 1'b1;
            end
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (bus.o_Busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (bus.o_Busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Runs one schedule; returns the index of its first captured subkey.
    task automatic run_sched(input logic [63:0] key, input bit dec, input bit pulse_restart, output int base);
        int          cyc;
        logic [63:0] other;
        wait_idle();
        push_exp(key, dec);
        base = hs_count;
        bus.i_Key      = key;
        bus.i_fDecrypt = dec;
        bus.i_Start    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Start = 1'b0;
        other = {$urandom, $urandom};
        bus.i_Key      = other;
        bus.i_fDecrypt = ~dec;
        chk("first_latency", {59'h0, bus.o_Valid, bus.o_Round}, {59'h0, 1'b1, 4'd0});
        cyc = 0;
        while (hs_count - base < 16 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.i_Start = pulse_restart && bus.o_Valid && (bus.o_Round == 4'd3 || bus.o_Round == 4'd15);
        end
        bus.i_Start = 1'b0;
        if (hs_count - base < 16) chk("run_timeout", 64'(hs_count - base), 64'd16);
        chk("done_outputs", {61'h0, bus.o_Valid, bus.o_Busy, bus.o_Last}, 64'h0);
        @(posedge clk);
        #1;
        chk("stays_idle", {62'h0, bus.o_Valid, bus.o_Busy}, 64'h0);
        chk("handshakes", 64'(hs_count - base), 64'd16);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int enc_base, dec_base, b, cyc;
        logic [63:0] k;
        rst            = 1'b1;
        bus.i_Start    = 1'b0;
        bus.i_Key      = '0;
        bus.i_fDecrypt = 1'b0;
        bus.i_Ready    = 1'b1;
        fork
            monitor_loop();
            ready_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {10'h0, bus.o_Valid, bus.o_Busy, bus.o_Last, bus.o_Round, bus.o_Subkey}, 64'h0);
        chk("reset_cd", {8'h0, dut.c_q, dut.d_q}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_sched(FIPS_KEY, 1'b0, 1'b0, enc_base);
        chk("fips_enc_k1", {16'h0, cap[enc_base]}, {16'h0, FIPS_K1});
        chk("fips_enc_k16", {16'h0, cap[enc_base+15]}, {16'h0, FIPS_K16});

        run_sched(FIPS_KEY, 1'b1, 1'b0, dec_base);
        chk("fips_dec_first", {16'h0, cap[dec_base]}, {16'h0, FIPS_K16});
        chk("fips_dec_last", {16'h0, cap[dec_base+15]}, {16'h0, FIPS_K1});
        for (int i = 0; i < 16; i++)
            chk("dec_reverse", {16'h0, cap[dec_base+i]}, {16'h0, cap[enc_base+15-i]});

        stall_en = 1'b1;
        run_sched(FIPS_KEY, 1'b0, 1'b0, b);
        for (int i = 0; i < 16; i++)
            chk("stall_same_seq", {16'h0, cap[b+i]}, {16'h0, cap[enc_base+i]});
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom};
            run_sched(k, 1'($urandom_range(0, 1)), 1'b0, b);
        end
        stall_en = 1'b0;
        wait_idle();
        @(posedge clk);
        #1;

        run_sched({$urandom, $urandom}, 1'b0, 1'b1, b);
        run_sched({$urandom, $urandom}, 1'b1, 1'b1, b);

        // Reset in the middle of a schedule.
        push_exp(FIPS_KEY, 1'b0);
        bus.i_Key      = FIPS_KEY;
        bus.i_fDecrypt = 1'b0;
        bus.i_Start    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Start = 1'b0;
        cyc = 0;
        while (!(bus.o_Valid && bus.o_Round == 4'd7) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reached_round7", {63'h0, bus.o_Valid}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("midrun_reset_outputs", {10'h0, bus.o_Valid, bus.o_Busy, bus.o_Last, bus.o_Round, bus.o_Subkey}, 64'h0);
        chk("midrun_reset_cd", {8'h0, dut.c_q, dut.d_q}, 64'h0);
        run_sched(FIPS_KEY, 1'b0, 1'b0, b);
        chk("restart_k1", {16'h0, cap[b]}, {16'h0, FIPS_K1});

        run_sched(64'h0, 1'b0, 1'b0, b);
        for (int i = 0; i < 16; i++) chk("zero_key", {16'h0, cap[b+i]}, 64'h0);
        run_sched(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, b);
        for (int i = 0; i < 16; i++) chk("ones_key", {16'h0, cap[b+i]}, 64'h0000FFFFFFFFFFFF);
        run_sched(64'h0101010101010101, 1'b0, 1'b0, b);
        for (int i = 0; i < 16; i++) chk("parity_key", {16'h0, cap[b+i]}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
